motor_output_stage: RTL and testbench



---
 rtl/motor_output_stage_if.sv | 34 +++
 rtl/motor_output_stage.sv | 206 ++++++++++++++++++++
 tb/tb_motor_output_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_output_stage_if.sv
// motor_output_stage_if
//   Command/status bundle between the flight controller side (master) and the
//   motor output stage (slave).
//   motor_rates  : packed per-motor commands, motor i at [i*RATE_WIDTH +: RATE_WIDTH]
//   rate_valid   : one-cycle strobe qualifying motor_rates
//   arm_request  : arm switch level from the receiver
//   throttle_low : throttle stick at minimum
//   motor_pwm    : ESC pulse outputs, one per motor
//   armed        : block is in ARMED
//   failsafe     : block is in FAILSAFE
//   frame_start  : one-cycle strobe after each frame boundary
interface motor_output_stage_if #(
    parameter int NUM_MOTORS = 4,
    parameter int RATE_WIDTH = 10
);
    logic [NUM_MOTORS*RATE_WIDTH-1:0] motor_rates;
    logic                             rate_valid;
    logic                             arm_request;
    logic                             throttle_low;
    logic [NUM_MOTORS-1:0]            motor_pwm;
    logic                             armed;
    logic                             failsafe;
    logic                             frame_start;

    modport master (
        output motor_rates, rate_valid, arm_request, throttle_low,
        input  motor_pwm, armed, failsafe, frame_start
    );

    modport slave (
        input  motor_rates, rate_valid, arm_request, throttle_low,
        output motor_pwm, armed, failsafe, frame_start
    );
endinterface

// File: rtl/motor_output_stage.sv
// motor_output_stage
//   N-motor ESC output stage: arming FSM, command-timeout failsafe,
//   frame-synchronous command update and optional slew limiting.
//   Everything runs on the 1 MHz us_clk; one count = one microsecond.
//
//   Ports:
//     us_clk  : 1 MHz clock
//     resetn  : synchronous active-low reset
//     bus     : motor_output_stage_if.slave (commands in, pulses/status out)
//
//   Build option: define MOTOR_SLEW_LIMIT_EN to limit each command's
//   per-frame increase to SLEW_STEP; decreases always apply at once.

// One motor channel: shadow/active command and the pulse comparator.
module motor_output_lane #(
    parameter int RATE_WIDTH   = 10,
    parameter int MAX_RATE     = 1000,
    parameter int MIN_PULSE_US = 1000,
    parameter int SLEW_STEP    = 16,
    parameter int CNT_W        = 12
) (
    input  logic                  us_clk,
    input  logic                  resetn,
    input  logic [RATE_WIDTH-1:0] cmd_i,
    input  logic                  rate_valid_i,
    input  logic                  boundary_i,
    input  logic                  run_i,
    input  logic [CNT_W-1:0]      frame_cnt_i,
    output logic                  pwm_o
);
`ifdef MOTOR_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif
    localparam logic [RATE_WIDTH-1:0] MAX_C  = RATE_WIDTH'(MAX_RATE);
    localparam logic [RATE_WIDTH:0]   STEP_C = (RATE_WIDTH+1)'(SLEW_STEP);
    localparam logic [CNT_W-1:0]      MIN_C  = CNT_W'(MIN_PULSE_US);

    logic [RATE_WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [RATE_WIDTH-1:0] clamped, target;
    logic [RATE_WIDTH:0]   slew_lim;
    logic [CNT_W-1:0]      pulse;
    logic                  pwm_q, pwm_d;

    always_comb begin
        clamped  = (cmd_i > MAX_C) ? MAX_C : cmd_i;
        shadow_d = rate_valid_i ? clamped : shadow_q;
        // shadow_d already carries the bypass value when the strobe lands
        // on the boundary cycle itself.
        target   = run_i ? shadow_d : '0;
        slew_lim = {1'b0, active_q} + STEP_C;
        active_d = active_q;
        if (boundary_i) begin
            if (SLEW_EN && ({1'b0, target} > slew_lim))
                active_d = slew_lim[RATE_WIDTH-1:0];
            else
                active_d = target;
        end
        // active_q only moves on the boundary, so the width is frame-stable.
        pulse = MIN_C + CNT_W'(active_q);
        pwm_d = frame_cnt_i < pulse;
    end

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

module motor_output_stage #(
    parameter int NUM_MOTORS      = 4,
    parameter int RATE_WIDTH      = 10,
    parameter int MAX_RATE        = 1000,
    parameter int MIN_PULSE_US    = 1000,
    parameter int PERIOD_US       = 2500,
    parameter int ARM_HOLD_FRAMES = 200,
    parameter int TIMEOUT_FRAMES  = 20,
    parameter int SLEW_STEP       = 16
) (
    input  logic                 us_clk,
    input  logic                 resetn,
    motor_output_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(PERIOD_US);
    localparam int HW    = $clog2(ARM_HOLD_FRAMES + 1);
    localparam int TW    = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_US - 1);

    typedef enum logic [1:0] {DISARMED, ARMING, ARMED, FAILSAFE} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      frame_cnt_q;
    logic [HW-1:0]         hold_cnt_q, hold_inc;
    logic [TW-1:0]         to_cnt_q, to_inc;
    logic                  seen_q, armed_q, failsafe_q, frame_start_q;
    logic                  boundary, sticks_ok, any_valid, hold_done, to_done, run;
    logic [NUM_MOTORS-1:0] pwm;

    always_comb begin
        boundary  = frame_cnt_q == LAST;
        sticks_ok = bus.arm_request && bus.throttle_low;
        // a strobe on the boundary cycle still counts for the frame ending now
        any_valid = seen_q || bus.rate_valid;
        hold_inc  = hold_cnt_q + 1'b1;
        to_inc    = to_cnt_q + 1'b1;
        hold_done = hold_inc >= HW'(ARM_HOLD_FRAMES);
        to_done   = to_inc >= TW'(TIMEOUT_FRAMES);
        // run: state after this boundary will be ARMED; lanes zero otherwise
        case (state_q)
            ARMING:  run = sticks_ok && hold_done;
            ARMED:   run = bus.arm_request && (any_valid || !to_done);
            default: run = 1'b0;
        endcase
    end

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state_q       <= DISARMED;
            frame_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            to_cnt_q      <= '0;
            seen_q        <= 1'b0;
            armed_q       <= 1'b0;
            failsafe_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= boundary;
            frame_cnt_q   <= boundary ? '0 : frame_cnt_q + 1'b1;
            seen_q        <= boundary ? 1'b0 : (seen_q || bus.rate_valid);
            if (boundary) begin
                armed_q <= run;
                case (state_q)
                    DISARMED:
                        if (sticks_ok) begin
                            state_q    <= ARMING;
                            hold_cnt_q <= HW'(1);
                        end
                    ARMING:
                        if (!sticks_ok) begin
                            state_q    <= DISARMED;
                            hold_cnt_q <= '0;
                        end else if (hold_done) begin
                            state_q    <= ARMED;
                            hold_cnt_q <= '0;
                            to_cnt_q   <= '0;
                        end else begin
                            hold_cnt_q <= hold_inc;
                        end
                    ARMED:
                        if (!bus.arm_request) begin
                            state_q <= DISARMED;
                        end else if (any_valid) begin
                            to_cnt_q <= '0;
                        end else if (to_done) begin
                            state_q    <= FAILSAFE;
                            failsafe_q <= 1'b1;
                            to_cnt_q   <= '0;
                        end else begin
                            to_cnt_q <= to_inc;
                        end
                    FAILSAFE:
                        // only way out is through DISARMED
                        if (!bus.arm_request) begin
                            state_q    <= DISARMED;
                            failsafe_q <= 1'b0;
                        end
                    default: state_q <= DISARMED;
                endcase
            end
        end
    end

    for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_lane
        motor_output_lane #(
            .RATE_WIDTH  (RATE_WIDTH),
            .MAX_RATE    (MAX_RATE),
            .MIN_PULSE_US(MIN_PULSE_US),
            .SLEW_STEP   (SLEW_STEP),
            .CNT_W       (CNT_W)
        ) u_lane (
            .us_clk      (us_clk),
            .resetn      (resetn),
            .cmd_i       (bus.motor_rates[m*RATE_WIDTH +: RATE_WIDTH]),
            .rate_valid_i(bus.rate_valid),
            .boundary_i  (boundary),
            .run_i       (run),
            .frame_cnt_i (frame_cnt_q),
            .pwm_o       (pwm[m])
        );
    end

    assign bus.motor_pwm   = pwm;
    assign bus.armed       = armed_q;
    assign bus.failsafe    = failsafe_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_motor_output_stage.sv
// tb_motor_output_stage
//   Directed bench for motor_output_stage with scaled-down timing
//   (40-cycle frames, 10-cycle idle pulse, commands clamped at 20).
//   A frame-level behavioural model predicts every output each cycle;
//   literal pulse-width/status expectations pin the model.
module tb_motor_output_stage;
    localparam int NM = 4, RW = 5, MAXR = 20, MINP = 10, PER = 40;
    localparam int HOLD = 4, TOF = 3, STEP = 4;

    logic            us_clk = 1'b0;
    logic            resetn = 1'b0;
    logic [NM*RW-1:0] rates = '0;
    logic            rv = 1'b0, arm = 1'b0, thr = 1'b0;

    always #5 us_clk = ~us_clk;

    motor_output_stage_if #(.NUM_MOTORS(NM), .RATE_WIDTH(RW)) bus();
    assign bus.motor_rates  = rates;
    assign bus.rate_valid   = rv;
    assign bus.arm_request  = arm;
    assign bus.throttle_low = thr;

    motor_output_stage #(
        .NUM_MOTORS(NM), .RATE_WIDTH(RW), .MAX_RATE(MAXR), .MIN_PULSE_US(MINP),
        .PERIOD_US(PER), .ARM_HOLD_FRAMES(HOLD), .TIMEOUT_FRAMES(TOF), .SLEW_STEP(STEP)
    ) dut (
        .us_clk(us_clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pos = microsecond within the frame; st: 0 disarmed, 1 arming, 2 armed, 3 failsafe
    int pos = 0, st = 0, hold = 0, tocnt = 0;
    bit seen = 0;
    int shadow[NM], act[NM];
    logic [NM-1:0] e_pwm = '0;
    logic e_arm = 0, e_fail = 0, e_fs = 0;

    function automatic int clampv(input int v);
        return (v > MAXR) ? MAXR : v;
    endfunction

    always @(posedge us_clk) begin : model
        int nst, cmd, tgt;
        if (!resetn) begin
            pos = 0; st = 0; hold = 0; tocnt = 0; seen = 0;
            for (int i = 0; i < NM; i++) begin shadow[i] = 0; act[i] = 0; end
            e_pwm = '0; e_arm = 0; e_fail = 0; e_fs = 0;
        end else begin
            for (int i = 0; i < NM; i++) e_pwm[i] = (pos < MINP + act[i]);
            e_fs = (pos == PER - 1);
            if (pos == PER - 1) begin
                nst = st;
                case (st)
                    0: if (arm && thr) begin nst = 1; hold = 1; end
                    1: if (!(arm && thr)) begin nst = 0; hold = 0; end
                       else begin
                           hold++;
                           if (hold >= HOLD) begin nst = 2; hold = 0; tocnt = 0; end
                       end
                    2: if (!arm) nst = 0;
                       else begin
                           if (seen || rv) tocnt = 0; else tocnt++;
                           if (tocnt >= TOF) begin nst = 3; tocnt = 0; end
                       end
                    default: if (!arm) nst = 0;
                endcase
                for (int i = 0; i < NM; i++) begin
                    cmd = rv ? clampv(int'(rates[i*RW +: RW])) : shadow[i];
                    tgt = (nst == 2) ? cmd : 0;
`ifdef MOTOR_SLEW_LIMIT_EN
                    if (tgt > act[i] + STEP) tgt = act[i] + STEP;
`endif
                    act[i] = tgt;
                end
                st = nst; seen = 0; pos = 0;
            end else begin
                pos++;
                if (rv) seen = 1;
            end
            if (rv) for (int i = 0; i < NM; i++) shadow[i] = clampv(int'(rates[i*RW +: RW]));
            e_arm  = (st == 2);
            e_fail = (st == 3);
        end
    end

    always @(posedge us_clk) begin : compare
        #1;
        chk("pwm", bus.motor_pwm, e_pwm);
        chk("armed", bus.armed, e_arm);
        chk("failsafe", bus.failsafe, e_fail);
        chk("frame_start", bus.frame_start, e_fs);
    end

    // ---------------- stimulus helpers ----------------
    int w[NM];

    task automatic tick();
        @(posedge us_clk);
        #1;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin tick(); n++; end while (bus.frame_start !== 1'b1 && n < 3*PER);
        chk("frame_start_wait", bus.frame_start, 1);
    endtask

    // Count high cycles per motor over one frame, optionally strobing v mid-frame.
    task automatic measure(input bit do_send, input logic [NM*RW-1:0] v);
        for (int i = 0; i < NM; i++) w[i] = 0;
        for (int j = 0; j < PER; j++) begin
            if (do_send && j == 3) begin rates = v; rv = 1'b1; end
            tick();
            rv = 1'b0;
            for (int i = 0; i < NM; i++) if (bus.motor_pwm[i] === 1'b1) w[i]++;
        end
    endtask

    task automatic chk_w(input string name, input int a, input int b, input int c, input int d);
        int e[NM];
        e = '{a, b, c, d};
        for (int i = 0; i < NM; i++) chk($sformatf("%s_m%0d", name, i), w[i], e[i]);
    endtask

    task automatic send(input logic [NM*RW-1:0] v);
        rates = v; rv = 1'b1;
        tick();
        rv = 1'b0;
    endtask

    function automatic logic [NM*RW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {RW'(d), RW'(c), RW'(b), RW'(a)};
    endfunction

    initial begin
        repeat (3) tick();
        chk("rst_pwm", bus.motor_pwm, 0);
        chk("rst_armed", bus.armed, 0);
        chk("rst_failsafe", bus.failsafe, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        resetn = 1'b1;

        wait_fs();
        measure(1'b0, '0);
        chk_w("idle", 10, 10, 10, 10);
        chk("idle_armed", bus.armed, 0);

        // throttle raised one frame before arming would complete
        arm = 1; thr = 1;
        repeat (3) wait_fs();
        thr = 0;
        wait_fs(); chk("abort_b4_armed", bus.armed, 0);
        wait_fs(); chk("abort_b5_armed", bus.armed, 0);
        arm = 0;
        wait_fs();

        // full arm sequence
        arm = 1; thr = 1;
        repeat (3) wait_fs();
        chk("arm_b3_armed", bus.armed, 0);
        wait_fs();
        chk("arm_b4_armed", bus.armed, 1);
        thr = 0;

        // steady commands with clamp: 0,10,20,31 -> widths 10,20,30,30
        for (int k = 0; k < 6; k++) begin
            repeat (3) tick();
            send(pack4(0, 10, 20, 31));
            wait_fs();
        end
        measure(1'b0, '0);
        chk_w("cmd", 10, 20, 30, 30);

        // strobe on the final cycle of the frame reaches the next frame
        repeat (PER - 1) tick();
        send(pack4(5, 0, 15, 2));
        chk("late_frame_start", bus.frame_start, 1);
        measure(1'b0, '0);
`ifdef MOTOR_SLEW_LIMIT_EN
        chk_w("late", 14, 10, 25, 12);
`else
        chk_w("late", 15, 10, 25, 12);
`endif

        // command timeout
        wait_fs();
        chk("to_failsafe_early", bus.failsafe, 0);
        chk("to_armed_early", bus.armed, 1);
        wait_fs();
        chk("to_failsafe", bus.failsafe, 1);
        chk("to_armed", bus.armed, 0);
        measure(1'b0, '0);
        chk_w("failsafe", 10, 10, 10, 10);
        thr = 1;
        wait_fs();
        chk("fs_no_rearm_failsafe", bus.failsafe, 1);
        chk("fs_no_rearm_armed", bus.armed, 0);
        arm = 0;
        wait_fs();
        chk("fs_exit_failsafe", bus.failsafe, 0);
        chk("fs_exit_armed", bus.armed, 0);

        // reset mid-pulse while armed
        arm = 1; thr = 1;
        repeat (4) wait_fs();
        chk("rearm_armed", bus.armed, 1);
        thr = 0;
        repeat (3) tick();
        send(pack4(20, 20, 20, 20));
        wait_fs();
        repeat (5) tick();
        chk("mid_pwm", bus.motor_pwm, 4'hF);
        resetn = 0;
        tick();
        chk("mid_rst_pwm", bus.motor_pwm, 0);
        chk("mid_rst_armed", bus.armed, 0);
        resetn = 1; arm = 0; thr = 0;
        measure(1'b0, '0);
        chk_w("post_rst", 10, 10, 10, 10);

`ifdef MOTOR_SLEW_LIMIT_EN
        // step 0->20 ramps by 4 per frame; step down is immediate
        arm = 1; thr = 1;
        repeat (4) wait_fs();
        thr = 0;
        measure(1'b1, pack4(20, 20, 20, 20));
        chk_w("ramp0", 10, 10, 10, 10);
        for (int k = 1; k <= 6; k++) begin
            measure(1'b1, pack4(20, 20, 20, 20));
            chk_w($sformatf("ramp%0d", k), 10 + 4*((k < 5) ? k : 5), 10 + 4*((k < 5) ? k : 5),
                  10 + 4*((k < 5) ? k : 5), 10 + 4*((k < 5) ? k : 5));
        end
        measure(1'b1, pack4(0, 0, 0, 0));
        chk_w("down_pre", 30, 30, 30, 30);
        measure(1'b0, '0);
        chk_w("down", 10, 10, 10, 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
